// File: rtl/pl_col_reader.sv
// pl_col_reader: sequencer at the end of the BRAM column readback chain.
// Drives the column select, waits a fixed settle time, captures the chain
// word and returns it on a valid/ready response channel. Supports single
// column reads, broadcast (col 0) and ascending column scans.
module pl_col_reader #(
    parameter int DATA_W        = 36,
    parameter int COL_W         = 10,
    parameter int NUM_COLS      = 16,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic              CLK_i,
    input  logic              RST_i,
    input  logic              REQ_VALID_i,
    output logic              REQ_READY_o,
    input  logic [COL_W-1:0]  REQ_COL_i,
    input  logic              REQ_SCAN_i,
    output logic [COL_W-1:0]  PL_COL_o,
    input  logic [DATA_W-1:0] CHAIN_DATA_i,
    output logic              RSP_VALID_o,
    input  logic              RSP_READY_i,
    output logic [DATA_W-1:0] RSP_DATA_o,
    output logic [COL_W-1:0]  RSP_COL_o,
    output logic              RSP_LAST_o,
    output logic              RSP_ERR_o,
    output logic              BUSY_o
);

    typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

    localparam logic [COL_W-1:0] MAX_COL  = COL_W'(NUM_COLS);
    localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
    localparam logic [7:0]       CNT_INIT = 8'(SETTLE_CYCLES);

    state_t            state_q, state_d;
    logic [COL_W-1:0]  cur_col;
    logic              scan;
    logic [7:0]        cnt;
    logic              accept;
    logic              req_bad;
    logic              rsp_fire;

    // Ready is suppressed while reset is held so nothing is accepted then.
    assign REQ_READY_o = (state_q == IDLE) && !RST_i;
    assign accept      = REQ_VALID_i && REQ_READY_o;
    assign req_bad     = REQ_COL_i > MAX_COL;
    assign RSP_VALID_o = (state_q == RESP);
    assign rsp_fire    = RSP_VALID_o && RSP_READY_i;
    assign BUSY_o      = (state_q != IDLE);

    // State register.
    always_ff @(posedge CLK_i) begin
        if (RST_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = req_bad ? RESP : SETTLE;
            SETTLE:  if (cnt == 8'd1) state_d = RESP;
            RESP:    if (rsp_fire) state_d = RSP_LAST_o ? IDLE : SETTLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: column select, settle counter and response capture. The
    // response fields only change on capture, so they hold through stalls.
    always_ff @(posedge CLK_i) begin
        if (RST_i) begin
            PL_COL_o   <= '0;
            cur_col    <= '0;
            scan       <= 1'b0;
            cnt        <= '0;
            RSP_DATA_o <= '0;
            RSP_COL_o  <= '0;
            RSP_LAST_o <= 1'b0;
            RSP_ERR_o  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (req_bad) begin
                            // Rejected: the chain is never touched.
                            RSP_ERR_o  <= 1'b1;
                            RSP_DATA_o <= '0;
                            RSP_COL_o  <= REQ_COL_i;
                            RSP_LAST_o <= 1'b1;
                        end else begin
                            PL_COL_o <= REQ_COL_i;
                            cur_col  <= REQ_COL_i;
                            scan     <= REQ_SCAN_i && (REQ_COL_i != '0);
                            cnt      <= CNT_INIT;
                        end
                    end
                end
                SETTLE: begin
                    cnt <= cnt - 8'd1;
                    if (cnt == 8'd1) begin
                        RSP_DATA_o <= CHAIN_DATA_i;
                        RSP_COL_o  <= cur_col;
                        RSP_ERR_o  <= 1'b0;
                        RSP_LAST_o <= !scan || (cur_col == MAX_COL);
                    end
                end
                RESP: begin
                    // Scan continues with the next column after each handshake.
                    if (rsp_fire && !RSP_LAST_o) begin
                        cur_col  <= cur_col + COL_ONE;
                        PL_COL_o <= cur_col + COL_ONE;
                        cnt      <= CNT_INIT;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pl_col_reader.sv
// Scoreboard bench for pl_col_reader: stimulus pushes expected words, a
// monitor pops them at each response handshake. Timing and reset checks
// are made inline by the stimulus process.
module tb_pl_col_reader;

    localparam int DATA_W = 36;
    localparam int COL_W  = 10;
    localparam int NCOLS  = 4;
    localparam int SETTLE = 3;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [COL_W-1:0]  col;
        logic              last;
        logic              err;
    } rsp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [COL_W-1:0]  req_col = '0;
    logic              req_scan = 1'b0;
    logic [COL_W-1:0]  pl_col;
    logic [DATA_W-1:0] chain_data;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [DATA_W-1:0] rsp_data;
    logic [COL_W-1:0]  rsp_col;
    logic              rsp_last;
    logic              rsp_err;
    logic              busy;

    int   checks = 0;
    int   errors = 0;
    rsp_t sb[$];

    pl_col_reader #(.DATA_W(DATA_W), .COL_W(COL_W), .NUM_COLS(NCOLS), .SETTLE_CYCLES(SETTLE)) dut (
        .CLK_i(clk), .RST_i(rst), .REQ_VALID_i(req_valid), .REQ_READY_o(req_ready),
        .REQ_COL_i(req_col), .REQ_SCAN_i(req_scan), .PL_COL_o(pl_col),
        .CHAIN_DATA_i(chain_data), .RSP_VALID_o(rsp_valid), .RSP_READY_i(rsp_ready),
        .RSP_DATA_o(rsp_data), .RSP_COL_o(rsp_col), .RSP_LAST_o(rsp_last),
        .RSP_ERR_o(rsp_err), .BUSY_o(busy)
    );

    always #5 clk = ~clk;

    // Chain model: column k returns k << k, broadcast ORs all columns.
    function automatic logic [DATA_W-1:0] chain_val(input logic [COL_W-1:0] c);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int k = 1; k <= NCOLS; k++)
            if (c == '0 || int'(c) == k) r = r | (DATA_W'(k) << k);
        return r;
    endfunction

    // Two-register delay from the column select to the chain output.
    logic [DATA_W-1:0] d1 = '0, d2 = '0;
    always @(posedge clk) begin
        d1 <= chain_val(pl_col);
        d2 <= d1;
    end
    assign chain_data = d2;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: compare at each handshake (sampled before the accepting edge).
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp col=%0d data=%0h", rsp_col, rsp_data);
            end else begin
                rsp_t e;
                e = sb.pop_front();
                chk("rsp_data", 64'(rsp_data), 64'(e.data));
                chk("rsp_col",  64'(rsp_col),  64'(e.col));
                chk("rsp_last", 64'(rsp_last), 64'(e.last));
                chk("rsp_err",  64'(rsp_err),  64'(e.err));
            end
        end
    end

    function automatic rsp_t mk(input logic [DATA_W-1:0] d, input logic [COL_W-1:0] c,
                                input logic l, input logic e);
        rsp_t r;
        r.data = d; r.col = c; r.last = l; r.err = e;
        return r;
    endfunction

    // Issue a request; returns just after the accepting edge.
    task automatic req(input logic [COL_W-1:0] c, input logic s);
        @(negedge clk);
        chk("req_ready_idle", 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_col = c; req_scan = s;
        @(posedge clk);
        #1 req_valid = 1'b0; req_scan = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 64'(busy), 64'd0);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_pl_col"},    64'(pl_col),    64'd0);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_rsp_data"},  64'(rsp_data),  64'd0);
        chk({tag, "_rsp_col"},   64'(rsp_col),   64'd0);
        chk({tag, "_rsp_last"},  64'(rsp_last),  64'd0);
        chk({tag, "_rsp_err"},   64'(rsp_err),   64'd0);
        chk({tag, "_busy"},      64'(busy),      64'd0);
    endtask

    initial begin
        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk_reset_outs("rst");
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_req_ready", 64'(req_ready), 64'd1);

        // Single read of column 2 with exact latency.
        sb.push_back(mk(36'h8, 10'd2, 1'b1, 1'b0));
        req(10'd2, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("single_valid", 64'(rsp_valid), 64'(i == 3));
            chk("single_pl_col", 64'(pl_col), 64'd2);
            chk("single_busy", 64'(busy), 64'd1);
        end
        @(negedge clk);
        chk("single_done_busy", 64'(busy), 64'd0);
        chk("single_done_ready", 64'(req_ready), 64'd1);

        // Broadcast with scan set: single word.
        sb.push_back(mk(36'h5A, 10'd0, 1'b1, 1'b0));
        req(10'd0, 1'b1);
        @(negedge clk);
        chk("bcast_pl_col", 64'(pl_col), 64'd0);
        wait_idle();

        // Scan from column 2: words after edges 3, 7, 11.
        sb.push_back(mk(36'h8,  10'd2, 1'b0, 1'b0));
        sb.push_back(mk(36'h18, 10'd3, 1'b0, 1'b0));
        sb.push_back(mk(36'h40, 10'd4, 1'b1, 1'b0));
        req(10'd2, 1'b1);
        for (int i = 0; i <= 12; i++) begin
            @(negedge clk);
            chk("scan_valid", 64'(rsp_valid), 64'(i == 3 || i == 7 || i == 11));
            chk("scan_busy", 64'(busy), 64'(i < 12));
            chk("scan_pl_col", 64'(pl_col), (i < 4) ? 64'd2 : (i < 8) ? 64'd3 : 64'd4);
        end

        // Backpressure on a read of column 1.
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        sb.push_back(mk(36'h2, 10'd1, 1'b1, 1'b0));
        req(10'd1, 1'b0);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_valid", 64'(rsp_valid), 64'd1);
            chk("bp_data", 64'(rsp_data), 64'h2);
            chk("bp_pl_col", 64'(pl_col), 64'd1);
            chk("bp_req_ready", 64'(req_ready), 64'd0);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        wait_idle();

        // Out-of-range column: error response one cycle after accept.
        sb.push_back(mk(36'h0, 10'd7, 1'b1, 1'b1));
        req(10'd7, 1'b0);
        @(negedge clk);
        chk("err_valid", 64'(rsp_valid), 64'd1);
        chk("err_flag", 64'(rsp_err), 64'd1);
        chk("err_pl_col", 64'(pl_col), 64'd1);
        wait_idle();

        // Reset during the settle of column 3 in a scan.
        sb.push_back(mk(36'h8, 10'd2, 1'b0, 1'b0));
        req(10'd2, 1'b1);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("midrst_pl_col_before", 64'(pl_col), 64'd3);
        chk("midrst_req_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_reset_outs("midrst");
        chk("midrst_ready_after", 64'(req_ready), 64'd1);
        repeat (6) @(negedge clk);
        chk("midrst_no_rsp", 64'(rsp_valid), 64'd0);
        sb.push_back(mk(36'h18, 10'd3, 1'b1, 1'b0));
        req(10'd3, 1'b0);
        wait_idle();

        repeat (2) @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
